// File: rtl/led_flow_sequencer.sv
// led_flow_sequencer
//   Step timebase and pattern generator for the 8-LED bank. Start/stop and mode
//   changes arrive as single-cycle pulses; mode changes made while running are
//   held pending and applied only on a step boundary so `led` never glitches.
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  synchronous active-high reset
//   start      in   1  pulse: begin sequencing from IDLE
//   stop       in   1  pulse: abort sequencing, return to IDLE
//   mode_req   in   2  requested pattern (0 up, 1 down, 2 ping-pong, 3 blink)
//   mode_load  in   1  pulse: capture mode_req
//   led        out  8  registered LED drive, active-high
//   busy       out  1  high while running
//   step_tick  out  1  high in the first cycle of each new led value
//   mode_cur   out  2  mode currently driving led
module led_flow_sequencer #(
    parameter int unsigned TICK_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode_req,
    input  logic       mode_load,
    output logic [7:0] led,
    output logic       busy,
    output logic       step_tick,
    output logic [1:0] mode_cur
);

    localparam logic [24:0] TickMax = 25'(TICK_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t      state;
    logic [24:0] cnt;
    logic [3:0]  idx;
    logic        dir;       // 0 = up, 1 = down (ping-pong only)
    logic [1:0]  mode_pend;
    logic        pend_vld;

    logic [3:0]  nxt_idx;
    logic        nxt_dir;
    logic [7:0]  nxt_led;
    logic        at_boundary;

    function automatic logic [7:0] first_led(input logic [1:0] m);
        unique case (m)
            2'd0:    first_led = 8'h01;
            2'd1:    first_led = 8'h80;
            2'd2:    first_led = 8'h01;
            default: first_led = 8'hFF;
        endcase
    endfunction

    assign at_boundary = (cnt == TickMax);

    // Next step of the current pattern when no mode change applies.
    always_comb begin
        nxt_idx = idx + 4'd1;
        nxt_dir = dir;
        nxt_led = 8'h00;
        unique case (mode_cur)
            2'd0: begin
                if (idx >= 4'd8) nxt_idx = 4'd0;
                nxt_led = (nxt_idx == 4'd8) ? 8'h00 : (8'h01 << nxt_idx[2:0]);
            end
            2'd1: begin
                if (idx >= 4'd8) nxt_idx = 4'd0;
                nxt_led = (nxt_idx == 4'd8) ? 8'h00 : (8'h80 >> nxt_idx[2:0]);
            end
            2'd2: begin
                // idx is the lit bit position; reverse at either end.
                if (!dir) begin
                    if (idx >= 4'd7) begin
                        nxt_idx = 4'd6;
                        nxt_dir = 1'b1;
                    end
                end else begin
                    if (idx == 4'd0) begin
                        nxt_idx = 4'd1;
                        nxt_dir = 1'b0;
                    end else begin
                        nxt_idx = idx - 4'd1;
                    end
                end
                nxt_led = 8'h01 << nxt_idx[2:0];
            end
            default: begin
                nxt_idx = {3'b000, ~idx[0]};
                nxt_led = idx[0] ? 8'hFF : 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= '0;
            idx       <= '0;
            dir       <= 1'b0;
            mode_cur  <= 2'd0;
            mode_pend <= 2'd0;
            pend_vld  <= 1'b0;
            led       <= 8'h00;
            busy      <= 1'b0;
            step_tick <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    cnt       <= '0;
                    idx       <= '0;
                    dir       <= 1'b0;
                    pend_vld  <= 1'b0;
                    led       <= 8'h00;
                    step_tick <= 1'b0;
                    if (mode_load) mode_cur <= mode_req;
                    if (start && !stop) begin
                        state     <= StRun;
                        busy      <= 1'b1;
                        step_tick <= 1'b1;
                        led       <= first_led(mode_load ? mode_req : mode_cur);
                    end
                end
                StRun: begin
                    if (stop) begin
                        state     <= StIdle;
                        busy      <= 1'b0;
                        cnt       <= '0;
                        idx       <= '0;
                        dir       <= 1'b0;
                        pend_vld  <= 1'b0;
                        led       <= 8'h00;
                        step_tick <= 1'b0;
                        if (mode_load) mode_cur <= mode_req;
                    end else if (at_boundary) begin
                        cnt       <= '0;
                        step_tick <= 1'b1;
                        if (mode_load || pend_vld) begin
                            // A load in the boundary cycle beats an older pending one.
                            mode_cur <= mode_load ? mode_req : mode_pend;
                            led      <= first_led(mode_load ? mode_req : mode_pend);
                            idx      <= '0;
                            dir      <= 1'b0;
                            pend_vld <= 1'b0;
                        end else begin
                            idx <= nxt_idx;
                            dir <= nxt_dir;
                            led <= nxt_led;
                        end
                    end else begin
                        cnt       <= cnt + 25'd1;
                        step_tick <= 1'b0;
                        if (mode_load) begin
                            mode_pend <= mode_req;
                            pend_vld  <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_led_flow_sequencer.sv
module tb_led_flow_sequencer;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode_req = 2'd0;
    logic       mode_load = 1'b0;
    logic [7:0] led;
    logic       busy;
    logic       step_tick;
    logic [1:0] mode_cur;

    int total = 0;
    int bad = 0;

    // Reference model: running flag, mode, position within the pattern's
    // sequence, cycles since last step, pending mode.
    bit       m_run = 0;
    int       m_mode = 0;
    int       m_pos = 0;
    int       m_cnt = 0;
    int       m_pend = 0;
    bit       m_pend_vld = 0;
    bit       m_tick = 0;

    led_flow_sequencer #(.TICK_CYCLES(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode_req  (mode_req),
        .mode_load (mode_load),
        .led       (led),
        .busy      (busy),
        .step_tick (step_tick),
        .mode_cur  (mode_cur)
    );

    always #5 clk = ~clk;

    function automatic int period(input int m);
        case (m)
            0, 1:    return 9;
            2:       return 14;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] pat(input int m, input int p);
        logic [7:0] one = 8'h01;
        logic [7:0] top = 8'h80;
        case (m)
            0:       return (p < 8) ? (one << p) : 8'h00;
            1:       return (p < 8) ? (top >> p) : 8'h00;
            2:       return (p < 8) ? (one << p) : (one << (14 - p));
            default: return (p % 2 == 0) ? 8'hFF : 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] exp_led();
        return m_run ? pat(m_mode, m_pos) : 8'h00;
    endfunction

    task automatic model_step(input bit st, input bit sp, input bit ml, input int mr,
                              input bit r);
        if (r) begin
            m_run = 0; m_mode = 0; m_pos = 0; m_cnt = 0; m_pend_vld = 0; m_tick = 0;
        end else if (!m_run) begin
            m_tick = 0;
            if (ml) m_mode = mr;
            if (st && !sp) begin
                m_run = 1; m_pos = 0; m_cnt = 0; m_tick = 1;
            end
        end else if (sp) begin
            m_run = 0; m_pos = 0; m_cnt = 0; m_pend_vld = 0; m_tick = 0;
            if (ml) m_mode = mr;
        end else if (m_cnt == T - 1) begin
            m_cnt = 0;
            m_tick = 1;
            if (ml) begin
                m_mode = mr; m_pos = 0; m_pend_vld = 0;
            end else if (m_pend_vld) begin
                m_mode = m_pend; m_pos = 0; m_pend_vld = 0;
            end else begin
                m_pos = (m_pos + 1) % period(m_mode);
            end
        end else begin
            m_cnt++;
            m_tick = 0;
            if (ml) begin
                m_pend = mr; m_pend_vld = 1;
            end
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, update model at the edge, compare 1 time unit later.
    task automatic cyc(input bit st, input bit sp, input bit ml, input logic [1:0] mr,
                       input bit r);
        start = st; stop = sp; mode_load = ml; mode_req = mr; rst = r;
        @(posedge clk);
        model_step(st, sp, ml, int'(mr), r);
        #1;
        start = 1'b0; stop = 1'b0; mode_load = 1'b0; rst = 1'b0;
        check8("led", led, exp_led());
        check8("busy", {7'b0, busy}, {7'b0, m_run});
        check8("step_tick", {7'b0, step_tick}, {7'b0, m_tick});
        check8("mode_cur", {6'b0, mode_cur}, 8'(m_mode));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, mode_req, 0);
    endtask

    initial begin
        // Reset then idle
        cyc(0, 0, 0, 2'd0, 1);
        cyc(0, 0, 0, 2'd0, 1);
        idle(20);
        check8("idle_led", led, 8'h00);

        // Flow-up run
        cyc(1, 0, 0, 2'd0, 0);
        check8("up_first", led, 8'h01);
        idle(4);
        check8("up_second", led, 8'h02);
        idle(40);
        cyc(0, 1, 0, 2'd0, 0);
        check8("stop_led", led, 8'h00);
        check8("stop_busy", {7'b0, busy}, 8'h00);

        // Ping-pong
        cyc(0, 0, 1, 2'd2, 0);
        cyc(1, 0, 0, 2'd2, 0);
        idle(14 * T + 8);
        cyc(0, 1, 0, 2'd2, 0);

        // Mid-run mode change
        cyc(0, 0, 1, 2'd0, 0);
        cyc(1, 0, 0, 2'd0, 0);
        idle(2 * T);
        check8("mid_04", led, 8'h04);
        cyc(0, 0, 1, 2'd3, 0);
        idle(2);
        check8("mid_hold", led, 8'h04);
        idle(1);
        check8("mid_ff", led, 8'hFF);
        check8("mid_mode", {6'b0, mode_cur}, 8'd3);
        cyc(0, 0, 1, 2'd3, 0);
        cyc(0, 0, 1, 2'd1, 0);
        idle(2);
        check8("last_wins", led, 8'h80);
        idle(10);
        cyc(0, 1, 0, 2'd1, 0);

        // Collisions
        cyc(0, 0, 1, 2'd0, 0);
        cyc(1, 1, 0, 2'd0, 0);
        check8("start_stop", {7'b0, busy}, 8'h00);
        cyc(1, 0, 0, 2'd0, 0);
        idle(2);
        cyc(1, 0, 0, 2'd0, 0);
        idle(1);
        check8("start_in_run", led, 8'h02);
        idle(2);
        cyc(0, 1, 0, 2'd0, 0);

        // Reset mid-operation with a pending mode
        cyc(0, 0, 1, 2'd3, 0);
        cyc(1, 0, 0, 2'd3, 0);
        cyc(0, 0, 1, 2'd2, 0);
        cyc(0, 0, 0, 2'd2, 1);
        check8("rst_led", led, 8'h00);
        check8("rst_mode", {6'b0, mode_cur}, 8'd0);
        idle(3);
        cyc(1, 0, 0, 2'd2, 0);
        check8("rst_restart", led, 8'h01);

        // Randomized pulses against the model
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(15) == 0), ($urandom_range(40) == 0),
                ($urandom_range(9) == 0), 2'($urandom_range(3)),
                ($urandom_range(200) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_flow_sequencer.md
# led_flow_sequencer

Sequencing controller for the 8-LED bank on the 25 MHz board. It generates the step timebase and chooses one of four lamp patterns. Start, stop and mode changes come from upstream key/command logic as single-cycle pulses. It owns the `led` outputs and keeps pattern changes glitch-free by applying mode changes only on step boundaries.

## Interface
Parameters
- `TICK_CYCLES`, default 2500000: clocks per pattern step (100 ms at 25 MHz). Legal range is 2 .. 2^25-1. The tick counter is 25 bits.

Ports
- `clk`  in  1: system clock, 25 MHz.
- `rst`  in  1: reset; one clock; reset is synchronous and active-high.
- `start`  in  1: single-cycle pulse; begin sequencing from IDLE.
- `stop`  in  1: single-cycle pulse; abort sequencing, return to IDLE.
- `mode_req`  in  2: requested pattern. 0 = flow-up, 1 = flow-down, 2 = ping-pong, 3 = blink.
- `mode_load`  in  1: single-cycle pulse; capture `mode_req`.
- `led`  out  8: LED drive, active-high, registered.
- `busy`  out  1: high while in RUN.
- `step_tick`  out  1: one-cycle pulse in the cycle a new `led` value first appears.
- `mode_cur`  out  2: mode currently driving `led`.

## Operation
- States:
  - IDLE: `led`=0, counter held at 0.
  - RUN: counter advances; `led` steps.
- Registers:
  - `cnt` (25 bits): tick counter.
  - `idx` (4 bits): step index.
  - `dir` (1 bit): ping-pong direction.
  - `mode_cur` (2 bits).
  - `mode_pend` (2 bits) and `pend_vld` (1 bit): pending mode.
- Step boundary: in RUN with `cnt`==TICK_CYCLES-1. On this edge `cnt`→0, `idx`/`led` advance, and `step_tick`=1.
- Patterns by `idx`:
  - mode 0: `idx` 0..7 gives `led`=1<<idx; `idx` 8 gives `led`=0 (all-off step); then wrap to 0. Period 9 steps.
  - mode 1: `idx` 0..7 gives `led`=8'h80>>idx; `idx` 8 gives 0. Period 9 steps.
  - mode 2: sequence 01,02,04,…,80,40,…,02, then repeat from 01. Period 14 steps. No all-off step; `dir` flips at 80 and at 01.
  - mode 3: FF, 00 alternating. Period 2 steps.
- IDLE → RUN on `start` (and no `stop`):
  - next edge: `busy`=1, `cnt`=0, `idx`=0, `led`= first pattern of `mode_cur` (01/80/01/FF), `step_tick`=1.
- RUN → IDLE on `stop`:
  - next edge: `led`=0, `busy`=0, `cnt`=0, `idx`=0, `dir`=up, `pend_vld`=0.
- `mode_load` in IDLE: `mode_cur`←`mode_req` at the next edge.
- `mode_load` in RUN: `mode_pend`←`mode_req`, `pend_vld`←1.
  - At the next step boundary: `mode_cur`←`mode_pend`, `idx`←0, `dir`←up, `led`← first pattern of the new mode, `pend_vld`←0.
  - A `mode_load` in the same cycle as a boundary applies at that boundary, using `mode_req` directly.
  - A later `mode_load` before the boundary overwrites the pending value (last wins).
- Loading the same mode as `mode_cur` still restarts the pattern at `idx` 0.
- Priorities, highest first: `rst` > `stop` > `start`.
  - `start`+`stop` in the same cycle: stop wins (IDLE stays IDLE).
  - `start` in RUN: ignored; counter not restarted.
  - `stop` in IDLE: ignored.
  - `stop` in the same cycle as a boundary: go to IDLE; no step occurs and `step_tick` stays 0.
  - `stop`+`mode_load` in RUN: go to IDLE; `mode_cur`←`mode_req`.

## Timing
- Reset values: `led`=0, `busy`=0, `step_tick`=0, `mode_cur`=0, internal state IDLE, `cnt`=0, `idx`=0, `dir`=up, `pend_vld`=0.
- Reset mid-RUN: all of the above at the next edge; the pending mode is discarded.
- All outputs are registered; there is no combinational input→output path.
- `start`→first `led`: 1 cycle. After that, `led` changes exactly every TICK_CYCLES cycles.
- `stop`→`led`=0: 1 cycle.
- `mode_load` in RUN → new pattern: lands on the next boundary, i.e. 1 to TICK_CYCLES cycles later.
- `step_tick` period in RUN is exactly TICK_CYCLES; it is never high in IDLE.

## Test plan (TICK_CYCLES=4)
- Reset then idle:
  - stimulus: assert `rst` for 2 cycles, release, wait 20 cycles.
  - required: `led`=00, `busy`=0, `step_tick` never high.
- Flow-up run:
  - stimulus: `start` pulse in mode 0.
  - required: 1 cycle later `led`=01; then 02,04,…,80,00,01 with each value held exactly 4 cycles; `step_tick` high in the first cycle of each value.
- Ping-pong:
  - stimulus: `mode_load` with `mode_req`=2 in IDLE, then `start`.
  - required: `led` follows 01,02,…,80,40,…,02,01,02; period 14 steps.
- Mid-run mode change:
  - stimulus: mode 0 running, `led`=04. Pulse `mode_load` with `mode_req`=3, 1 cycle after the boundary.
  - required: `led` stays 04 for the full 4 cycles, then FF, then 00, FF; `mode_cur`=3 from that boundary.
  - also: a second `mode_load` with `mode_req`=1 before the boundary gives 80 instead (last wins).
- Stop and collisions:
  - `stop` in RUN: `led`=00 and `busy`=0 next cycle.
  - `start`+`stop` in the same cycle from IDLE: remains IDLE.
  - `start` during RUN: step timing unchanged.
- Reset mid-operation:
  - stimulus: `rst` asserted during RUN with a pending mode.
  - required: next cycle `led`=00, `mode_cur`=0. After the following `start`, `led`=01.
